// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//
// Constants and types shared by the fetch stage and the rest of the
// integer pipeline (decode, hazard unit).
//
//   NOP_WORD          encoding decode sees for bubbles and flushed slots
//   OP_*              primary opcode values (instruction bits 31:26, which
//                     the ISA manual numbers as bits 0:5)
//   fetch_state_t     fetch sequencer state encoding
//   word_align()      clears the byte-offset bits of an address
//   is_load/branch/jr opcode class helpers used by the hazard logic
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD = 32'h5400_0000;

    localparam logic [5:0] OP_LOAD_FIRST   = 6'h20;
    localparam logic [5:0] OP_LOAD_LAST    = 6'h27;
    localparam logic [5:0] OP_BRANCH_FIRST = 6'h04;
    localparam logic [5:0] OP_BRANCH_LAST  = 6'h07;
    localparam logic [5:0] OP_JR           = 6'h12;
    localparam logic [5:0] OP_JALR         = 6'h13;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LOAD_FIRST) && (op <= OP_LOAD_LAST);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BRANCH_FIRST) && (op <= OP_BRANCH_LAST);
    endfunction

    function automatic logic is_jr(input logic [5:0] op);
        return (op == OP_JR) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//
// Instruction-memory request/acknowledge bus.
//
//   imem_req    fetch request, held with imem_addr stable until imem_ack
//   imem_addr   word address of the request (low two bits always zero)
//   imem_ack    response valid this cycle; only meaningful while imem_req=1
//   imem_rdata  instruction word, valid with imem_ack
//
// master: the fetch stage. slave: instruction memory.
// ----------------------------------------------------------------------------
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC, issues one word fetch at a time over
// the imem req/ack bus and fills the IF/ID latch read by decode and the
// fetch hazard logic. A one-entry hold buffer catches a response that lands
// while the pipe is held, so that word is never fetched twice.
//
// Ports:
//   clk                clock
//   rst                synchronous active-high reset
//   imem               instruction memory bus (master side)
//   pc_stall_i         hold PC and IF/ID latch
//   need_nop_i         hold IF/ID latch (decode injects the bubble)
//   redirect_valid_i   decode resolved a taken branch / jump / jr
//   redirect_target_i  new PC (byte offset bits ignored)
//   if_instr_o         IF/ID instruction
//   if_pc_plus_4_o     IF/ID PC+4
//   if_valid_o         IF/ID holds a real instruction
//
// State  | meaning
// -------+----------------------------------------------------------------
// FETCH  | request outstanding at pc; an ack is consumed this cycle
// HOLD   | a response arrived during a hold and sits in the buffer; no req
// FLUSH  | redirected while a fetch was in flight; keep the stale request
//        | stable until its ack, then drop the data
//
// Priority on every cycle: rst > redirect > hold > normal advance.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  imem,
    input  logic          pc_stall_i,
    input  logic          need_nop_i,
    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_target_i,
    output logic [31:0]   if_instr_o,
    output logic [31:0]   if_pc_plus_4_o,
    output logic          if_valid_o
);

    localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q,   buf_pc4_d;
    logic [31:0] if_instr_q,  if_instr_d;
    logic [31:0] if_pc4_q,    if_pc4_d;
    logic        if_valid_q,  if_valid_d;

    logic        hold;
    logic        ack;
    logic [31:0] target_al;
    logic [31:0] pc_plus_4;
    logic        req_c;
    logic [31:0] addr_c;

    assign hold      = pc_stall_i | need_nop_i;
    assign ack       = imem.imem_ack;
    assign target_al = word_align(redirect_target_i);
    // 32-bit add, so the PC wraps from 0xFFFF_FFFC to 0.
    assign pc_plus_4 = pc_q + 32'd4;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC_AL;
            req_addr_q  <= RESET_PC_AL;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= 32'h0;
            if_instr_q  <= NOP_INSTR;
            if_pc4_q    <= 32'h0;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        if_instr_d  = if_instr_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        req_c       = 1'b0;
        addr_c      = pc_q;

        unique case (state_q)
            ST_FETCH: begin
                // Request drops during the reset cycle; memory abandons it.
                req_c      = ~rst;
                addr_c     = pc_q;
                req_addr_d = pc_q;
                if (redirect_valid_i) begin
                    pc_d       = target_al;
                    if_instr_d = NOP_INSTR;
                    if_pc4_d   = 32'h0;
                    if_valid_d = 1'b0;
                    // A same-cycle ack closes the old fetch, so its data
                    // is simply dropped; otherwise wait it out in FLUSH.
                    state_d    = ack ? ST_FETCH : ST_FLUSH;
                end else if (ack) begin
                    pc_d = pc_plus_4;
                    if (hold) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc4_d   = pc_plus_4;
                        state_d     = ST_HOLD;
                    end else begin
                        if_instr_d = imem.imem_rdata;
                        if_pc4_d   = pc_plus_4;
                        if_valid_d = 1'b1;
                    end
                end else if (!hold) begin
                    if_instr_d = NOP_INSTR;
                    if_pc4_d   = 32'h0;
                    if_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                req_c = 1'b0;
                if (redirect_valid_i) begin
                    pc_d       = target_al;
                    if_instr_d = NOP_INSTR;
                    if_pc4_d   = 32'h0;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!hold) begin
                    if_instr_d = buf_instr_q;
                    if_pc4_d   = buf_pc4_q;
                    if_valid_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_FLUSH: begin
                // Memory expects the address held stable until ack, so the
                // stale request stays on the bus; pc already has the target.
                req_c  = ~rst;
                addr_c = req_addr_q;
                if (redirect_valid_i) begin
                    pc_d = target_al;
                end
                if (ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;

    assign if_instr_o     = if_instr_q;
    assign if_pc_plus_4_o = if_pc4_q;
    assign if_valid_o     = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Stimulus (negedge): acts as instruction memory with random ack latency,
// and randomly raises holds and redirects. A transaction-level model of the
// fetch stream predicts the address of each new request and which responses
// must reach the IF/ID latch; the expected latch contents go into a queue.
// Monitor (posedge + 1): pops and compares each newly delivered instruction
// and checks latch hold / flush / bubble behaviour.
// A second instance with RESET_PC = 0xFFFF_FFFC checks PC wrap.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall, need_nop, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_instr, if_pc4;
    logic        if_valid;
    logic [31:0] if_instr2, if_pc42;
    logic        if_valid2;

    fetch_unit_if imem_if ();
    fetch_unit_if imem_if2 ();

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem              (imem_if),
        .pc_stall_i        (pc_stall),
        .need_nop_i        (need_nop),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .if_instr_o        (if_instr),
        .if_pc_plus_4_o    (if_pc4),
        .if_valid_o        (if_valid)
    );

    fetch_unit #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (NOP)
    ) dut_wrap (
        .clk               (clk),
        .rst               (rst),
        .imem              (imem_if2),
        .pc_stall_i        (1'b0),
        .need_nop_i        (1'b0),
        .redirect_valid_i  (1'b0),
        .redirect_target_i (32'h0),
        .if_instr_o        (if_instr2),
        .if_pc_plus_4_o    (if_pc42),
        .if_valid_o        (if_valid2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    // Wrap instance: memory answers every request in the same cycle.
    assign imem_if2.imem_ack   = imem_if2.imem_req;
    assign imem_if2.imem_rdata = mem_word(imem_if2.imem_addr);

    int vectors    = 0;
    int miscompares = 0;
    int deliveries = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb_q[$];

    // Reference model of the fetch stream
    logic [31:0] model_pc;
    logic        in_txn;
    logic [31:0] txn_addr;
    logic        txn_stale;
    int          txn_wait;
    int          txn_lat;
    logic        pending;
    int          cyc;
    int          valid_run;

    task automatic do_reset(input int cycles, input logic [31:0] start_pc, input bit check_wrap);
        @(negedge clk);
        rst = 1'b1;
        pc_stall = 1'b0; need_nop = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
        sb_q.delete();
        pending = 1'b0;
        in_txn  = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_pc = start_pc;
        cyc = 0;
        #1;
        if (check_wrap) begin
            chk("wrap_req0", {31'b0, imem_if2.imem_req}, 32'h1);
            chk("wrap_addr0", imem_if2.imem_addr, 32'hFFFF_FFFC);
        end
    endtask

    // One cycle of stimulus. lat < 0 => random latency 0..3.
    task automatic step(input int lat, input int hold_pct, input int redir_pct, input bit check_wrap);
        logic        hold, redir, ack, coin;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        if (!in_txn) begin
            chk("req_when_idle", {31'b0, imem_if.imem_req}, {31'b0, ~pending});
            if (imem_if.imem_req) begin
                chk("req_addr_start", imem_if.imem_addr, model_pc);
                in_txn    = 1'b1;
                txn_addr  = model_pc;
                txn_stale = 1'b0;
                txn_wait  = 0;
                txn_lat   = (lat < 0) ? $urandom_range(0, 3) : lat;
            end
        end else begin
            chk("req_held", {31'b0, imem_if.imem_req}, 32'h1);
            chk("addr_stable", imem_if.imem_addr, txn_addr);
        end

        if (check_wrap && cyc == 1) begin
            chk("wrap_valid", {31'b0, if_valid2}, 32'h1);
            chk("wrap_pc4", if_pc42, 32'h0000_0000);
            chk("wrap_instr", if_instr2, mem_word(32'hFFFF_FFFC));
            chk("wrap_next_addr", imem_if2.imem_addr, 32'h0000_0000);
        end
        if (check_wrap && cyc == 2) begin
            chk("wrap_pc4_b", if_pc42, 32'h0000_0004);
            chk("wrap_addr_b", imem_if2.imem_addr, 32'h0000_0004);
        end

        hold  = ($urandom_range(0, 99) < hold_pct);
        redir = ($urandom_range(0, 99) < redir_pct);
        coin  = $urandom_range(0, 1) == 1;
        tgt   = $urandom;
        ack   = in_txn && imem_if.imem_req && (txn_wait >= txn_lat);

        pc_stall         = hold & coin;
        need_nop         = hold & ~coin;
        redirect_valid   = redir;
        redirect_target  = tgt;
        imem_if.imem_ack = ack;
        imem_if.imem_rdata = ack ? mem_word(imem_if.imem_addr) : $urandom;

        // A buffered response is lost to a redirect, delivered on release.
        if (pending) begin
            if (redir) begin
                if (sb_q.size() > 0) void'(sb_q.pop_back());
                pending = 1'b0;
            end else if (!hold) begin
                pending = 1'b0;
            end
        end
        if (ack) begin
            in_txn = 1'b0;
            if (!redir && !txn_stale) begin
                sb_q.push_back('{mem_word(txn_addr), txn_addr + 32'd4});
                model_pc = txn_addr + 32'd4;
                pending  = hold;
            end
        end else if (in_txn) begin
            txn_wait++;
            if (redir) txn_stale = 1'b1;
        end
        if (redir) model_pc = tgt & 32'hFFFF_FFFC;
    endtask

    // Monitor
    logic [31:0] prev_instr, prev_pc4;
    logic        prev_valid;
    logic        mon_delivery;
    exp_t        mon_e;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_valid", {31'b0, if_valid}, 32'h0);
            chk("rst_instr", if_instr, NOP);
            chk("rst_pc4", if_pc4, 32'h0);
            chk("rst_req", {31'b0, imem_if.imem_req}, 32'h0);
        end else begin
            if (redirect_valid) begin
                chk("flush_valid", {31'b0, if_valid}, 32'h0);
                chk("flush_instr", if_instr, NOP);
            end else if (pc_stall || need_nop) begin
                chk("hold_instr", if_instr, prev_instr);
                chk("hold_pc4", if_pc4, prev_pc4);
                chk("hold_valid", {31'b0, if_valid}, {31'b0, prev_valid});
            end else if (!if_valid) begin
                chk("bubble_instr", if_instr, NOP);
            end
            mon_delivery = if_valid && (!prev_valid || if_instr != prev_instr || if_pc4 != prev_pc4);
            if (!redirect_valid && !pc_stall && !need_nop)
                chk("no_stale_latch", {31'b0, if_valid && !mon_delivery}, 32'h0);
            if (mon_delivery) begin
                deliveries++;
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_instr: got %h pc4 %h, expected none (t=%0t)", if_instr, if_pc4, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("instr", if_instr, mon_e.instr);
                    chk("pc_plus_4", if_pc4, mon_e.pc4);
                end
            end
        end
        prev_instr = if_instr;
        prev_pc4   = if_pc4;
        prev_valid = if_valid;
    end

    initial begin
        rst = 1'b1;
        pc_stall = 1'b0; need_nop = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
        pending = 1'b0; in_txn = 1'b0; model_pc = 32'h0;
        txn_addr = 32'h0; txn_stale = 1'b0; txn_wait = 0; txn_lat = 0; cyc = 0;

        do_reset(2, 32'h0, 1'b1);

        // Combinational ack: one instruction per cycle after the first.
        valid_run = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1'b1);
            if (cyc >= 2 && if_valid) valid_run++;
        end
        chk("b2b_throughput", valid_run, 19);

        // Fixed three-cycle latency, no holds or redirects.
        for (int i = 0; i < 16; i++) step(3, 0, 0, 1'b0);

        // Random mix of latency, holds and redirects.
        for (int i = 0; i < 3000; i++) step(-1, 25, 10, 1'b0);

        // Reset mid-stream, then heavier hold/redirect traffic.
        do_reset(1, 32'h0, 1'b0);
        for (int i = 0; i < 500; i++) step(-1, 40, 20, 1'b0);

        // Drain: let any buffered response through.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1'b0);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("enough_deliveries", {31'b0, deliveries > 200}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage feeding the IF/ID latch that the fetch hazard logic and decode read. It owns the PC and issues word requests to instruction memory over a req/ack handshake of variable latency. It holds the IF/ID latch on stall or bubble requests, and redirects on branch or jump resolution from decode. A one-entry hold buffer catches a response that returns while the pipe is stalled, so that response is never refetched.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
NOP_INSTR, 32'h5400_0000, encoding placed in the latch for bubbles and flushes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request; held with imem_addr stable until imem_ack
imem_addr  out  32  word address; bits [30:31] always 2'b00
imem_ack  in  1  response valid this cycle; only meaningful while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
pc_stall  in  1  hold PC and IF/ID latch
need_nop  in  1  hold IF/ID latch (bubble goes to decode; treated as hold here)
redirect_valid  in  1  decode resolved taken branch / jump / jr
redirect_target  in  32  new PC; bits [30:31] forced to 0
if_instr  out  32  IF/ID latched instruction; opcode = bits [0:5]
if_pc_plus_4  out  32  IF/ID latched PC+4
if_valid  out  1  latch holds a real instruction

Behaviour:
- hold = pc_stall | need_nop.
- Registers: pc, req_addr, state {FETCH, HOLD, FLUSH}, buf_instr, buf_pc4, IF/ID latch.
- Reset (sync): pc=RESET_PC; state=FETCH; if_instr=NOP_INSTR; if_pc_plus_4=0; if_valid=0; buffer cleared. imem_req=0 during the reset cycle.
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
- FETCH: imem_req=1, imem_addr=pc (req_addr<=pc). One fetch outstanding at most.
  - redirect_valid: pc<=target, latch<=NOP/valid 0.
    - If imem_ack this cycle: response dropped, stay FETCH.
    - Else: go FLUSH.
  - ack & !hold: latch<=(rdata, pc+4, valid 1); pc<=pc+4. Latency 1 cycle after ack; back-to-back fetches at one instruction per cycle when ack is combinational.
  - ack & hold: buf<=(rdata, pc+4); pc<=pc+4; latch unchanged; go HOLD.
  - !ack & !hold: latch<=NOP, valid 0 (bubble).
  - !ack & hold: latch unchanged.
- HOLD: imem_req=0.
  - redirect: pc<=target, latch<=NOP/valid 0, buffer discarded, go FETCH.
  - !hold: latch<=buf, valid 1, go FETCH.
  - else stay.
- FLUSH: imem_req=1, imem_addr=req_addr (stale address kept stable).
  - On ack: data discarded, go FETCH.
  - A further redirect overwrites pc with the newest target and stays in FLUSH.
  - Latch stays NOP/valid 0.
- Priority: rst > redirect_valid > hold > normal advance.
- rst mid-transaction: the outstanding fetch is abandoned. Memory must tolerate req dropping before ack after reset.

Decomposition:
- Shared pipeline package: opcode constants (load 6'h20-6'h27, branch 6'h04-6'h07, jr/jalr 6'h12/6'h13), NOP_INSTR, fetch state encoding.
- No sub-module needed; the hazard unit stays a separate instance driving pc_stall/need_nop.

Test Plan:
1. Reset, then ack every cycle with mem[n]=n+0x20000000 -> imem_addr 0,4,8,...; if_instr/if_pc_plus_4 = (0x20000000,4), (0x20000001,8), ...; if_valid=1 from the first ack+1.
2. Ack latency 3 -> imem_addr=0 stable for 3 cycles; if_valid=0 with if_instr=NOP_INSTR until the edge after ack; next request is addr 4.
3. pc_stall=1 on the ack cycle for 2 cycles -> latch unchanged, imem_req=0 in HOLD; on release the buffered instr appears with if_pc_plus_4=prev+4; next imem_addr=prev+4, no refetch.
4. Redirect to 0x100 while waiting (no ack) -> FLUSH keeps the old address until ack; that data never reaches if_instr; next imem_addr=0x100, then if_pc_plus_4=0x104.
5. redirect_valid and pc_stall both high with ack -> pc=target, latch NOP/valid 0, ack data dropped.
6. RESET_PC=0xFFFFFFFC, ack each cycle -> if_pc_plus_4=0x00000000, next imem_addr=0x00000000.
